// File: rtl/fft_pkg.sv
// Shared definitions for the fft input loader: FSM state encoding and default
// frame geometry.
package fft_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int WORDSIZE_DEF   = 16;
    localparam int NUMSAMPLES_DEF = 256;
    localparam int ADDRSIZE_DEF   = $clog2(NUMSAMPLES_DEF / 4);
endpackage

// File: rtl/fft_loader_bank.sv
// One quarter-frame sample bank: synchronous write, registered read that holds
// its value whenever no read is requested.
module fft_loader_bank #(
    parameter int WORDSIZE = 16,
    parameter int ADDRSIZE = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [WORDSIZE-1:0] wdata,
    input  logic                re,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [WORDSIZE-1:0] rdata
);
    logic [WORDSIZE-1:0] mem [0:(1<<ADDRSIZE)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fft_input_loader.sv
// Buffers one serial frame into four banks, then bursts it to fft stage 0 as
// N/4 four-lane beats holding radix-4 butterfly inputs.
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int WORDSIZE   = WORDSIZE_DEF,
    parameter int NUMSAMPLES = NUMSAMPLES_DEF,
    parameter int ADDRSIZE   = ADDRSIZE_DEF,
    parameter int GAPCYCLES  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                in_valid,
    input  logic [WORDSIZE-1:0] in_data,
    output logic                in_ready,
    output logic                wr_en,
    output logic [WORDSIZE-1:0] data_out0,
    output logic [WORDSIZE-1:0] data_out1,
    output logic [WORDSIZE-1:0] data_out2,
    output logic [WORDSIZE-1:0] data_out3,
    output logic                busy,
    output logic                frame_done
);
    localparam int LOGN = $clog2(NUMSAMPLES);
    localparam int GAPW = (GAPCYCLES > 1) ? $clog2(GAPCYCLES) : 1;

    state_t              state;
    logic [LOGN-1:0]     fill_cnt;
    logic [ADDRSIZE-1:0] send_cnt;
    logic [GAPW-1:0]     gap_cnt;
    logic                accept;
    logic                sending;
    logic [WORDSIZE-1:0] lane [4];

    assign in_ready = (state == FILL);
    assign accept   = in_valid & in_ready;
    assign sending  = (state == SEND);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fill_cnt   <= '0;
            send_cnt   <= '0;
            gap_cnt    <= '0;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // Bank reads land one cycle after the address, so wr_en trails SEND by one.
            wr_en      <= sending;
            frame_done <= wr_en & ~sending;
            case (state)
                IDLE: if (en) state <= FILL;
                FILL: if (accept) begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (&fill_cnt) state <= SEND;
                end
                SEND: begin
                    send_cnt <= send_cnt + 1'b1;
                    if (&send_cnt) state <= GAP;
                end
                GAP: begin
                    if (gap_cnt == GAPW'(GAPCYCLES - 1)) begin
                        gap_cnt <= '0;
                        state   <= en ? FILL : IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Top two bits of the sample index pick the bank, so beat j gathers x[j + b*N/4].
    for (genvar b = 0; b < 4; b++) begin : g_bank
        fft_loader_bank #(
            .WORDSIZE(WORDSIZE),
            .ADDRSIZE(ADDRSIZE)
        ) u_bank (
            .clk  (clk),
            .rst  (rst),
            .we   (accept && (fill_cnt[LOGN-1 -: 2] == 2'(b))),
            .waddr(fill_cnt[ADDRSIZE-1:0]),
            .wdata(in_data),
            .re   (sending),
            .raddr(send_cnt),
            .rdata(lane[b])
        );
    end

    assign data_out0 = lane[0];
    assign data_out1 = lane[1];
    assign data_out2 = lane[2];
    assign data_out3 = lane[3];
endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader: frame-level reference model built
// from the radix-4 lane placement rule, plus reset and back-to-back sequences.
module tb_fft_input_loader;
    localparam int W  = 16;
    localparam int N  = 256;
    localparam int Q  = N / 4;
    localparam int GC = 2;

    logic          clk = 1'b0;
    logic          rst, en, in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready, wr_en, busy, frame_done;
    logic [W-1:0]  data_out0, data_out1, data_out2, data_out3;

    int total = 0;
    int bad   = 0;
    bit abort_ok = 1'b0;
    logic [W-1:0] frame [N];

    fft_input_loader #(.WORDSIZE(W), .NUMSAMPLES(N), .ADDRSIZE(6), .GAPCYCLES(GC)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .data_out0(data_out0), .data_out1(data_out1),
        .data_out2(data_out2), .data_out3(data_out3), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          toggle;
        bit          rnd;
        bit          junk;
        logic [W-1:0] base;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] d);
        int t = 0;
        in_valid = 1'b1; in_data = d;
        while (!in_ready && t < 1000) begin @(negedge clk); t++; end
        if (t >= 1000) chk("push_timeout", 65'(t), 65'(0));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_frame(input bit toggle, input bit drop_en);
        for (int n = 0; n < N; n++) begin
            push(frame[n]);
            if (n == 0 && drop_en) en = 1'b0;
            if (toggle && n < N - 1) @(negedge clk);
        end
        chk("ready_low_after_fill", 65'(in_ready), 65'(0));
    endtask

    // Reference: beat j carries x[j], x[j+N/4], x[j+N/2], x[j+3N/4] on lanes 0..3.
    task automatic check_burst(input int exp_lat, input bit junk);
        int t = 0;
        if (junk) begin in_valid = 1'b1; in_data = 16'hDEAD; end
        while (!wr_en && t < 50) begin @(negedge clk); t++; end
        chk("first_beat_latency", 65'(t), 65'(exp_lat));
        if (t >= 50) begin in_valid = 1'b0; return; end
        for (int j = 0; j < Q; j++) begin
            chk($sformatf("beat%0d", j), {wr_en, data_out3, data_out2, data_out1, data_out0},
                {1'b1, frame[j + 3*Q], frame[j + 2*Q], frame[j + Q], frame[j]});
            if (junk) chk($sformatf("ready_in_send%0d", j), 65'(in_ready), 65'(0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("burst_end_done_pulse", 65'({wr_en, frame_done}), 65'(2'b01));
        @(negedge clk);
        chk("done_one_cycle", 65'(frame_done), 65'(0));
    endtask

    // Burst length and inter-burst gap invariants, watched continuously.
    initial begin
        int hi = 0, lo = 0;
        bit prev = 1'b0, seen = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_en) begin
                if (!prev && seen) begin
                    total++;
                    if (lo < GC) begin bad++; $display("FAIL gap_len got=%0d min=%0d", lo, GC); end
                end
                hi++; lo = 0;
            end else begin
                if (prev) begin
                    if (!abort_ok) begin
                        total++;
                        if (hi != Q) begin bad++; $display("FAIL burst_len got=%0d want=%0d", hi, Q); end
                    end
                    seen = 1'b1;
                end
                hi = 0; lo++;
            end
            prev = wr_en;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [4];
        int   any;
        vecs[0] = '{toggle: 1'b0, rnd: 1'b0, junk: 1'b0, base: 16'h0000, exp_lat: 1};
        vecs[1] = '{toggle: 1'b1, rnd: 1'b0, junk: 1'b1, base: 16'h0000, exp_lat: 1};
        vecs[2] = '{toggle: 1'b0, rnd: 1'b1, junk: 1'b0, base: 16'h0000, exp_lat: 1};
        vecs[3] = '{toggle: 1'b1, rnd: 1'b1, junk: 1'b1, base: 16'h0000, exp_lat: 1};

        do_reset();
        chk("reset_state", 65'({wr_en, busy, in_ready, frame_done,
                                data_out0, data_out1, data_out2, data_out3}), 65'(0));

        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int n = 0; n < N; n++)
                frame[n] = vecs[v].rnd ? W'($urandom) : (vecs[v].base | W'(n));
            en = 1'b1;
            push_frame(vecs[v].toggle, 1'b1);
            check_burst(vecs[v].exp_lat, vecs[v].junk);
            chk($sformatf("idle_after_frame%0d", v), 65'({busy, in_ready}), 65'(0));
        end

        // Back-to-back frames with en held high.
        do_reset();
        en = 1'b1;
        for (int n = 0; n < N; n++) frame[n] = W'(n);
        push_frame(1'b0, 1'b0);
        check_burst(1, 1'b0);
        chk("refill_ready", 65'(in_ready), 65'(1));
        for (int n = 0; n < N; n++) frame[n] = 16'h8000 | W'(n);
        push_frame(1'b0, 1'b1);
        check_burst(1, 1'b0);

        // Reset after 100 accepted samples, then a clean frame.
        do_reset();
        en = 1'b1;
        for (int n = 0; n < 100; n++) push(16'h1111);
        rst = 1'b1; @(negedge clk); rst = 1'b0; en = 1'b0;
        chk("mid_fill_reset", 65'({busy, in_ready, wr_en}), 65'(0));
        for (int n = 0; n < N; n++) frame[n] = 16'h4000 | W'(N - 1 - n);
        en = 1'b1;
        push_frame(1'b0, 1'b1);
        check_burst(1, 1'b0);

        // Reset at beat 10 of SEND.
        do_reset();
        for (int n = 0; n < N; n++) frame[n] = W'($urandom);
        en = 1'b1;
        push_frame(1'b0, 1'b1);
        any = 0;
        while (!wr_en && any < 50) begin @(negedge clk); any++; end
        repeat (10) @(negedge clk);
        abort_ok = 1'b1;
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        chk("mid_send_reset", 65'({wr_en, busy, in_ready, frame_done}), 65'(0));
        any = 0;
        repeat (70) begin
            @(negedge clk);
            if (wr_en || frame_done) any++;
        end
        chk("no_done_after_abort", 65'(any), 65'(0));
        abort_ok = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
